npu_cube_acc_ctrl: RTL and testbench
====================================

Name: npu_cube_acc_ctrl

Overview:
- Sequencer and accumulator behind the NPU cube adder tree.
- Takes the resolved per-beat dot-product result from the tree's final carry-propagate stage over a valid/ready stream.
- Accumulates a programmed number of beats into one signed result, with saturation, and hands the result downstream over a second valid/ready stream.
- Provides start/busy/done control for the cube scheduler.

Parameters:
- DWS, 21, width of signed per-beat input from the adder tree.
- DWACC, 32, width of signed accumulator and output.
- LENW, 8, width of the beat-count field.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_start  input  1  start pulse; sampled only in IDLE.
- cfg_len  input  LENW  beats per accumulation; latched on an accepted cfg_start.
- cfg_clr  input  1  synchronous abort; returns the block to IDLE.
- busy  output  1  high in ACC or OUT.
- done  output  1  one-cycle pulse on output handshake.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  DWS  signed two's-complement beat.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DWACC  signed accumulated result.
- out_ovf  output  1  saturation occurred in this accumulation; valid with out_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, acc=0, cnt=0, len_q=0, ovf=0, in_ready=0, out_valid=0, done=0, busy=0, out_data=0, out_ovf=0.
- States: IDLE, ACC, OUT.

IDLE:
- in_ready=0, out_valid=0.
- cfg_start=1 latches len_q=cfg_len and clears acc, cnt and ovf.
- Next state is ACC if cfg_len!=0, else OUT with acc=0. An empty job still produces one result.

ACC:
- in_ready=1 combinationally while in ACC (no dependence on in_valid).
- A handshake (in_valid & in_ready) performs acc <= sat(acc + sext(in_data)) and cnt <= cnt+1.
- The handshake with cnt==len_q-1 moves the state to OUT.
- out_valid rises the cycle after the last-beat handshake, so latency from the final beat to result is 1 cycle.

Saturation:
- Overflow is detected when the two addends share a sign and the sum's sign differs.
- On overflow, acc clamps to +2^(DWACC-1)-1 or -2^(DWACC-1) by addend sign, and ovf sets.
- Once ovf is set, acc holds its clamped value for the remaining beats. Beats are still consumed and counted.

OUT:
- out_valid=1, out_data=acc, out_ovf=ovf. All three are held stable until out_ready.
- The cycle out_valid & out_ready are both high: done=1 for that single cycle, and the next state is IDLE.
- out_valid stays high with out_ready=0 indefinitely (back-pressure), with no data change.

Control rules:
- cfg_start outside IDLE is ignored; len_q is not disturbed.
- cfg_clr has priority over every other event in any state: next state IDLE, acc/cnt/ovf cleared, no done pulse. A beat presented in that cycle is not consumed, so in_ready=0 when cfg_clr=1.
- cfg_start and cfg_clr together in IDLE: cfg_clr wins and the start is dropped.
- busy = (state!=IDLE).
- Reset mid-ACC or mid-OUT: all outputs immediately go to their reset values, and the pending result is lost.
- cnt width is LENW; the maximum length 2^LENW-1 beats completes without wrap.
- Widths: in_data is sign-extended to DWACC+1 for the add. DWACC >= DWS+LENW guarantees no saturation at default parameters; saturation is reachable only with a reduced DWACC.

Test Plan:
- Basic accumulate: cfg_len=4, beats 100, -30, 7, 1000 with in_valid held high -> out_valid 1 cycle after 4th handshake, out_data=1077, out_ovf=0, done pulses once on out_ready.
- Input gaps and output back-pressure: cfg_len=3, in_valid toggles 1,0,1,0,1 with beats -5,-5,-5; out_ready held 0 for 10 cycles -> out_data=-15 and out_valid held stable for all 10 cycles; done only in the handshake cycle; in_ready=0 during OUT.
- Zero length: cfg_len=0 -> no input consumed (in_ready stays 0), out_valid the next cycle with out_data=0, busy high until handshake.
- Saturation (DWACC=24, DWS=21): cfg_len=10, each beat +2^20-1 -> out_data=2^23-1, out_ovf=1, all 10 beats consumed. Repeat with -2^20 -> out_data=-2^23.
- Abort and ignore-start: cfg_len=5, cfg_clr after 2 beats -> IDLE next cycle, no done, busy=0; then cfg_start during a new ACC run with cfg_len=9 -> ignored, the run completes at its original length.
- Async reset: assert rst_n low mid-OUT between clock edges -> out_valid, busy, in_ready go 0 without waiting for a clock edge; after release, a fresh cfg_len=1 job with beat 42 yields 42.

Source files
------------

// File: rtl/npu_cube_acc_ctrl.sv
// Purpose: sequences and accumulates cfg_len dot-product beats from the cube adder tree into one saturating signed result.
// Latency: the result is valid 1 cycle after the final input handshake. A zero-length job presents 0 one cycle after start.
// Backpressure: in_ready is high only in ACC. out_valid, out_data and out_ovf hold until out_ready. cfg_clr aborts at once.
module npu_cube_acc_ctrl #(
    parameter int DWS   = 21,
    parameter int DWACC = 32,
    parameter int LENW  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_start,
    input  logic [LENW-1:0]         cfg_len,
    input  logic                    cfg_clr,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DWS-1:0]          in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DWACC-1:0]        out_data,
    output logic                    out_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [DWACC-1:0] ACC_MAX = {1'b0, {(DWACC-1){1'b1}}};
    localparam logic [DWACC-1:0] ACC_MIN = {1'b1, {(DWACC-1){1'b0}}};

    state_t             state;
    state_t             state_nxt;
    logic [DWACC-1:0]   acc;
    logic [LENW-1:0]    cnt;
    logic [LENW-1:0]    len_q;
    logic               ovf;

    logic [DWACC:0]     sum_ext;
    logic               sum_ovf;
    logic [DWACC-1:0]   acc_sat;
    logic               last_beat;
    logic               in_hs;
    logic               out_hs;

    // One guard bit above the accumulator makes overflow a simple compare of the top two sum bits.
    always_comb begin
        sum_ext = {acc[DWACC-1], acc} + {{(DWACC+1-DWS){in_data[DWS-1]}}, in_data};
        sum_ovf = sum_ext[DWACC] ^ sum_ext[DWACC-1];
        acc_sat = sum_ext[DWACC-1:0];
        if (sum_ovf) begin
            acc_sat = in_data[DWS-1] ? ACC_MIN : ACC_MAX;
        end
    end

    assign last_beat = (cnt == (len_q - LENW'(1)));
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready & ~cfg_clr;
    assign out_data  = acc;
    assign out_ovf   = ovf;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs. cfg_clr overrides everything, including the beat and the result handshake.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    state_nxt = (cfg_len != '0) ? S_ACC : S_OUT;
                end
            end
            S_ACC: begin
                in_ready = ~cfg_clr;
                if (in_valid && !cfg_clr && last_beat) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready && !cfg_clr) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (cfg_clr) begin
            state_nxt = S_IDLE;
        end
    end

    // Datapath: the job length is latched on start, beats are accumulated, and the accumulator is cleared after abort or result delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else if (cfg_clr) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        len_q <= cfg_len;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                S_ACC: begin
                    if (in_hs) begin
                        cnt <= cnt + LENW'(1);
                        // After the first clamp the value is pinned; later beats are only counted.
                        if (!ovf) begin
                            acc <= acc_sat;
                            ovf <= sum_ovf;
                        end
                    end
                end
                S_OUT: begin
                    if (out_hs) begin
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end
                end
                default: begin
                    acc <= '0;
                    cnt <= '0;
                    ovf <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npu_cube_acc_ctrl.sv
// Purpose: directed self-checking bench for npu_cube_acc_ctrl. It uses the default instance and a narrowed DWACC=24 instance.
// Latency: each test drives inputs 1ns after the rising edge and samples shortly afterwards, away from the edge.
// Backpressure: out_ready is held low for stretches to exercise result hold.
module tb_npu_cube_acc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [7:0]  cfg_len = 8'd0;
    logic        cfg_clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [20:0] in_data = 21'd0;
    logic        out_ready = 1'b0;

    logic        busy, done, in_ready, out_valid, out_ovf;
    logic [31:0] out_data;
    logic        busy_s, done_s, in_ready_s, out_valid_s, out_ovf_s;
    logic [23:0] out_data_s;

    int n_tests = 0;
    int n_fail  = 0;

    npu_cube_acc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_clr(cfg_clr),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    npu_cube_acc_ctrl #(.DWS(21), .DWACC(24), .LENW(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_clr(cfg_clr),
        .busy(busy_s), .done(done_s), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_ovf(out_ovf_s)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] len);
        cfg_start = 1'b1;
        cfg_len   = len;
        cyc();
        cfg_start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) cyc();
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_tests++; if (out_ovf !== 1'b0)   begin n_fail++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        int beats[4];
        beats[0] = 100; beats[1] = -30; beats[2] = 7; beats[3] = 1000;
        start_job(8'd4);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got %b want 1", in_ready); end
        n_tests++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 21'(beats[i]);
            #1;
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid beat %0d got %b want 0", i, out_valid); end
            cyc();
        end
        in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
        n_tests++; if (out_data !== 32'd1077) begin n_fail++; $display("FAIL basic_out_data got %0d want 1077", $signed(out_data)); end
        n_tests++; if (out_data_s !== 24'd1077) begin n_fail++; $display("FAIL basic_out_data_s got %0d want 1077", $signed(out_data_s)); end
        n_tests++; if (out_ovf !== 1'b0)      begin n_fail++; $display("FAIL basic_out_ovf got %b want 0", out_ovf); end
        n_tests++; if (done !== 1'b0)         begin n_fail++; $display("FAIL basic_done_early got %b want 0", done); end
        n_tests++; if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL basic_in_ready_out got %b want 0", in_ready); end
        out_ready = 1'b1;
        #1;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", done); end
        cyc();
        out_ready = 1'b0;
        #1;
        n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL basic_done_after got %b want 0", done); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_after got %b want 0", out_valid); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL basic_busy_after got %b want 0", busy); end
    endtask

    task automatic test_gaps_backpressure();
        start_job(8'd3);
        in_data = 21'h1FFFFB;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            #1;
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early_valid cycle %0d got %b want 0", i, out_valid); end
            cyc();
        end
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            n_tests++; if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL bp_valid cycle %0d got %b want 1", k, out_valid); end
            n_tests++; if (out_data !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL bp_data cycle %0d got %0d want -15", k, $signed(out_data)); end
            n_tests++; if (done !== 1'b0)         begin n_fail++; $display("FAIL bp_done cycle %0d got %b want 0", k, done); end
            n_tests++; if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL bp_in_ready cycle %0d got %b want 0", k, in_ready); end
            cyc();
        end
        out_ready = 1'b1;
        #1;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done_hs got %b want 1", done); end
        cyc();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL bp_done_after got %b want 0", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_after got %b want 0", busy); end
    endtask

    task automatic test_zero_len();
        in_valid = 1'b1;
        in_data  = 21'd77;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_in_ready_idle got %b want 0", in_ready); end
        start_job(8'd0);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL zero_in_ready cycle %0d got %b want 0", k, in_ready); end
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid cycle %0d got %b want 1", k, out_valid); end
            n_tests++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL zero_data cycle %0d got %0d want 0", k, $signed(out_data)); end
            n_tests++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL zero_busy cycle %0d got %b want 1", k, busy); end
            cyc();
        end
        out_ready = 1'b1;
        #1;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b want 1", done); end
        cyc();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after got %b want 0", busy); end
    endtask

    task automatic test_saturation();
        logic [20:0] sbeat[2];
        logic [23:0] exp24[2];
        logic [31:0] exp32[2];
        int hs;
        sbeat[0] = 21'h0FFFFF; exp24[0] = 24'h7FFFFF; exp32[0] = 32'd10485750;
        sbeat[1] = 21'h100000; exp24[1] = 24'h800000; exp32[1] = 32'hFF600000;
        for (int s = 0; s < 2; s++) begin
            start_job(8'd10);
            in_valid = 1'b1;
            in_data  = sbeat[s];
            hs = 0;
            for (int i = 0; i < 10; i++) begin
                #1;
                if (in_ready_s && in_valid) hs++;
                cyc();
            end
            in_valid = 1'b0;
            #1;
            n_tests++; if (hs !== 10)              begin n_fail++; $display("FAIL sat_beats case %0d got %0d want 10", s, hs); end
            n_tests++; if (out_valid_s !== 1'b1)   begin n_fail++; $display("FAIL sat_valid case %0d got %b want 1", s, out_valid_s); end
            n_tests++; if (out_data_s !== exp24[s]) begin n_fail++; $display("FAIL sat_data case %0d got %h want %h", s, out_data_s, exp24[s]); end
            n_tests++; if (out_ovf_s !== 1'b1)     begin n_fail++; $display("FAIL sat_ovf case %0d got %b want 1", s, out_ovf_s); end
            n_tests++; if (out_data !== exp32[s])  begin n_fail++; $display("FAIL wide_data case %0d got %h want %h", s, out_data, exp32[s]); end
            n_tests++; if (out_ovf !== 1'b0)       begin n_fail++; $display("FAIL wide_ovf case %0d got %b want 0", s, out_ovf); end
            out_ready = 1'b1;
            #1;
            n_tests++; if (done_s !== 1'b1) begin n_fail++; $display("FAIL sat_done case %0d got %b want 1", s, done_s); end
            cyc();
            out_ready = 1'b0;
            #1;
            n_tests++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL sat_busy_after case %0d got %b want 0", s, busy_s); end
        end
    endtask

    task automatic test_abort_ignore_start();
        start_job(8'd5);
        in_valid = 1'b1;
        in_data  = 21'd10;
        cyc();
        in_data  = 21'd20;
        cyc();
        cfg_clr = 1'b1;
        in_data = 21'd30;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_in_ready got %b want 0", in_ready); end
        n_tests++; if (done !== 1'b0)     begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
        cyc();
        cfg_clr  = 1'b0;
        in_valid = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", out_valid); end
        n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL abort_done_after got %b want 0", done); end
        cfg_start = 1'b1;
        cfg_clr   = 1'b1;
        cfg_len   = 8'd2;
        cyc();
        cfg_start = 1'b0;
        cfg_clr   = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_beats_start got busy %b want 0", busy); end
        start_job(8'd3);
        in_valid = 1'b1;
        in_data  = 21'd1;
        cyc();
        cfg_start = 1'b1;
        cfg_len   = 8'd9;
        cyc();
        cfg_start = 1'b0;
        cyc();
        in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ignore_start_valid got %b want 1", out_valid); end
        n_tests++; if (out_data !== 32'd3) begin n_fail++; $display("FAIL ignore_start_data got %0d want 3", $signed(out_data)); end
        out_ready = 1'b1;
        #1;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL ignore_start_done got %b want 1", done); end
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        start_job(8'd1);
        in_valid = 1'b1;
        in_data  = 21'd5;
        cyc();
        in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid got %b want 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b want 0", out_valid); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL arst_busy got %b want 0", busy); end
        n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL arst_in_ready got %b want 0", in_ready); end
        n_tests++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL arst_data got %h want 0", out_data); end
        #2;
        rst_n = 1'b1;
        cyc();
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_post_valid got %b want 0", out_valid); end
        start_job(8'd1);
        in_valid = 1'b1;
        in_data  = 21'd42;
        cyc();
        in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL arst_job_valid got %b want 1", out_valid); end
        n_tests++; if (out_data !== 32'd42) begin n_fail++; $display("FAIL arst_job_data got %0d want 42", $signed(out_data)); end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps_backpressure();
        test_zero_len();
        test_saturation();
        test_abort_ignore_start();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
